// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: CPU-side arbiter that launches the DMA engine.
// It handles a device-ready event by pulsing cmd and waiting for BR. It then waits for
// the CPU's in-flight access to finish and grants the bus while stalling the CPU.
// It reclaims the bus when BR drops and pulses dma_done.
// BR and grant timeouts park the block in a terminal error state until reset.
// A device event that arrives while busy is kept as pending. A second event that
// arrives while one is already pending is dropped and flagged as an overrun.
module dma_bus_arbiter #(
    parameter int BR_TIMEOUT = 16,
    parameter int MAX_GRANT  = 32,
    parameter int CNT_W      = 6
) (
    input  logic CLK,
    input  logic reset,
    input  logic dev_irq,
    input  logic cpu_mem_req,
    input  logic BR,
    output logic BG,
    output logic cmd,
    output logic cpu_stall,
    output logic dma_done,
    output logic overrun,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WAIT_BR  = 3'd2,
        WAIT_CPU = 3'd3,
        GRANT    = 3'd4,
        RELEASE  = 3'd5,
        ERR      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] BR_LAST      = CNT_W'(BR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GRANT_LAST   = CNT_W'(MAX_GRANT - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic               pending_reg, pending_next;
    logic               overrun_reg, overrun_next;
    logic               bg_reg, cmd_reg, stall_reg, done_reg, err_reg;

    // Saturating increment so a long stay never wraps the counter back into range.
    always_comb begin
        cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    end

    // Next-state, counter and event-bookkeeping logic.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_inc;
        pending_next = pending_reg;
        overrun_next = overrun_reg;

        case (state_reg)
            IDLE: begin
                if (dev_irq || pending_reg) begin
                    state_next = CMD;
                end
                // A stored event is consumed now; a simultaneous new one takes its place.
                pending_next = pending_reg & dev_irq;
            end
            CMD: begin
                cnt_next   = '0;
                state_next = WAIT_BR;
            end
            WAIT_BR: begin
                if (BR) begin
                    if (!cpu_mem_req) begin
                        state_next = GRANT;
                        cnt_next   = '0;
                    end else begin
                        state_next = WAIT_CPU;
                    end
                end else if (cnt_reg == BR_LAST) begin
                    state_next = ERR;
                end
            end
            WAIT_CPU: begin
                if (!cpu_mem_req) begin
                    state_next = GRANT;
                    cnt_next   = '0;
                end
            end
            GRANT: begin
                if (!BR) begin
                    state_next = RELEASE;
                end else if (cnt_reg == GRANT_LAST) begin
                    state_next = ERR;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Events arriving while a transfer is in progress are queued one deep.
        if (dev_irq && (state_reg != IDLE) && (state_reg != ERR)) begin
            if (pending_reg) begin
                overrun_next = 1'b1;
            end else begin
                pending_next = 1'b1;
            end
        end
    end

    // State, counter and bookkeeping registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
        end
    end

    // Registered outputs decoded from the state being entered, so each one is valid for the whole state.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            bg_reg    <= 1'b0;
            cmd_reg   <= 1'b0;
            stall_reg <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            bg_reg    <= (state_next == GRANT);
            cmd_reg   <= (state_next == CMD);
            stall_reg <= (state_next == WAIT_CPU) || (state_next == GRANT) ||
                         (state_next == RELEASE);
            done_reg  <= (state_next == RELEASE);
            err_reg   <= (state_next == ERR);
        end
    end

    assign BG        = bg_reg;
    assign cmd       = cmd_reg;
    assign cpu_stall = stall_reg;
    assign dma_done  = done_reg;
    assign overrun   = overrun_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: the bench drives the arbiter through transactions.
// Each transaction is described by its BR delay, CPU busy time, grant length and
// extra device events. Expected outputs come from a timeline computed arithmetically
// from those parameters.
module tb_dma_bus_arbiter;

    localparam int BR_TO = 16;
    localparam int MG    = 32;

    logic CLK = 1'b0;
    logic reset;
    logic dev_irq;
    logic cpu_mem_req;
    logic BR;
    logic BG;
    logic cmd;
    logic cpu_stall;
    logic dma_done;
    logic overrun;
    logic err;

    int   checks   = 0;
    int   failures = 0;
    logic ovr_exp  = 1'b0;

    dma_bus_arbiter #(
        .BR_TIMEOUT (BR_TO),
        .MAX_GRANT  (MG),
        .CNT_W      (6)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .dev_irq     (dev_irq),
        .cpu_mem_req (cpu_mem_req),
        .BR          (BR),
        .BG          (BG),
        .cmd         (cmd),
        .cpu_stall   (cpu_stall),
        .dma_done    (dma_done),
        .overrun     (overrun),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string pfx, input logic e_bg, input logic e_cmd,
                             input logic e_stall, input logic e_done,
                             input logic e_ovr, input logic e_err);
        chk({pfx, ".BG"},        BG,        e_bg);
        chk({pfx, ".cmd"},       cmd,       e_cmd);
        chk({pfx, ".cpu_stall"}, cpu_stall, e_stall);
        chk({pfx, ".dma_done"},  dma_done,  e_done);
        chk({pfx, ".overrun"},   overrun,   e_ovr);
        chk({pfx, ".err"},       err,       e_err);
    endtask

    // Quiet cycles: nothing may move except the sticky overrun flag.
    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            dev_irq     = 1'b0;
            BR          = 1'b0;
            cpu_mem_req = 1'b0;
            @(negedge CLK);
            check_all($sformatf("%s.idle%0d", name, i), 1'b0, 1'b0, 1'b0, 1'b0, ovr_exp, 1'b0);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset(input string name);
        dev_irq     = 1'b0;
        BR          = 1'b0;
        cpu_mem_req = 1'b0;
        reset       = 1'b1;
        ovr_exp     = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_all({name, ".rst"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge CLK);
        #1;
        $display("reset %s", name);
    endtask

    // One DMA transaction. Cycle 0 is the IDLE cycle that starts it, either by
    // a dev_irq pulse or by an event left pending from the previous transfer.
    task automatic run_txn(input int id, input bit from_pending, input int bd,
                           input int busy, input int glen, input int n_extra,
                           input int abort_at, output bit next_pending);
        int   t_br, t_g, gend, err_c, last, x1, x2;
        bit   br_to, g_to;
        logic e_bg, e_cmd, e_stall, e_done, e_ovr, e_err;
        string pfx;

        br_to = (bd >= BR_TO);
        t_br  = 2 + bd;
        t_g   = t_br + busy + 1;
        g_to  = !br_to && (glen > MG);
        gend  = g_to ? t_g + MG : t_g + glen;
        err_c = br_to ? 2 + BR_TO : gend;
        x1    = -1;
        x2    = -1;
        if (br_to || g_to) begin
            // Events after the error must be ignored.
            last = err_c + 3;
            x1   = err_c + 1;
            x2   = err_c + 2;
        end else begin
            last = gend;
            if (n_extra >= 1) x1 = $urandom_range(gend, t_g);
            if (n_extra >= 2) begin
                x2 = $urandom_range(gend - 1, t_g);
                if (x2 >= x1) x2++;
            end
        end
        next_pending = 1'b0;

        for (int k = 0; k <= last; k++) begin
            dev_irq     = (k == 0 && !from_pending) || (k == x1) || (k == x2);
            BR          = !br_to && (k >= t_br) && (g_to || k <= t_g + glen - 2);
            cpu_mem_req = !br_to && (k >= t_br) && (k < t_br + busy);
            @(negedge CLK);
            e_cmd = (k == 1);
            if (br_to) begin
                e_bg    = 1'b0;
                e_stall = 1'b0;
                e_done  = 1'b0;
                e_err   = (k >= err_c);
            end else begin
                e_bg    = (k >= t_g) && (k < gend);
                e_stall = (k >= t_br + 1) && (g_to ? (k < gend) : (k <= gend));
                e_done  = !g_to && (k == gend);
                e_err   = g_to && (k >= gend);
            end
            e_ovr = ovr_exp || (!br_to && !g_to && n_extra == 2 &&
                                k > ((x1 > x2) ? x1 : x2));
            pfx = $sformatf("t%0d.c%0d", id, k);
            check_all(pfx, e_bg, e_cmd, e_stall, e_done, e_ovr, e_err);
            if (k == abort_at) begin
                // Asynchronous reset must drop everything without waiting for a clock edge.
                reset = 1'b1;
                #1;
                check_all({pfx, ".async"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                dev_irq     = 1'b0;
                BR          = 1'b0;
                cpu_mem_req = 1'b0;
                ovr_exp     = 1'b0;
                @(negedge CLK);
                reset = 1'b0;
                @(posedge CLK);
                #1;
                $display("txn %0d bd=%0d busy=%0d len=%0d aborted by reset at c%0d",
                         id, bd, busy, glen, k);
                return;
            end
            @(posedge CLK);
            #1;
        end
        dev_irq     = 1'b0;
        BR          = 1'b0;
        cpu_mem_req = 1'b0;
        if (!br_to && !g_to) begin
            next_pending = (n_extra > 0);
            if (n_extra == 2) ovr_exp = 1'b1;
        end
        $display("txn %0d pend_start=%0d bd=%0d busy=%0d len=%0d extra=%0d grant=[%0d,%0d)",
                 id, from_pending, bd, busy, glen, n_extra, t_g, gend);
    endtask

    initial begin
        bit pend;
        int bd, busy, glen, nx;

        reset       = 1'b1;
        dev_irq     = 1'b0;
        cpu_mem_req = 1'b0;
        BR          = 1'b0;
        pend        = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge CLK);
        #1;
        idle_cycles(2, "start");

        // Basic transfer, CPU-busy transfer, BR just inside its timeout with a full-length grant.
        run_txn(1, 1'b0, 0, 0, 13, 0, -1, pend);
        idle_cycles(2, "g1");
        run_txn(2, 1'b0, 1, 3, 5, 0, -1, pend);
        idle_cycles(1, "g2");
        run_txn(3, 1'b0, BR_TO - 1, 0, MG, 0, -1, pend);
        idle_cycles(1, "g3");

        // One queued event, then two more (overrun), then the final queued one.
        run_txn(4, 1'b0, 2, 1, 10, 1, -1, pend);
        run_txn(5, pend, 0, 0, 4, 2, -1, pend);
        run_txn(6, pend, 1, 0, 1, 0, -1, pend);
        idle_cycles(2, "g6");
        do_reset("after_overrun");

        // Randomised transfers, chained through pending events where they occur.
        for (int t = 0; t < 30; t++) begin
            bd   = ($urandom_range(7, 0) == 0) ? BR_TO - 1 : $urandom_range(8, 0);
            busy = $urandom_range(4, 0);
            glen = ($urandom_range(5, 0) == 0) ? MG : $urandom_range(MG, 1);
            nx   = $urandom_range(2, 0);
            run_txn(10 + t, pend, bd, busy, glen, nx, -1, pend);
            if (!pend) idle_cycles($urandom_range(3, 0), $sformatf("r%0d", t));
        end
        if (pend) run_txn(40, 1'b1, 0, 0, 3, 0, -1, pend);
        idle_cycles(1, "rand_end");
        do_reset("after_random");

        // Grant timeout, then BR timeout; events during ERR are ignored.
        run_txn(50, 1'b0, 0, 1, MG + 8, 0, -1, pend);
        do_reset("after_grant_timeout");
        run_txn(51, 1'b0, BR_TO, 0, 5, 0, -1, pend);
        do_reset("after_br_timeout");

        // Reset in the middle of a grant; afterwards the block stays idle.
        run_txn(52, 1'b0, 1, 0, 20, 0, 9, pend);
        idle_cycles(4, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
